// File: rtl/bit8_boot_mem.sv
// ---------------------------------------------------------------------------
// bit8_boot_mem
//
// Program/data memory that sits in front of the 8-bit state-machine core.
// After reset it keeps the core in reset and loads a program image from a
// valid/ready byte stream. The image is a length byte, then the payload
// bytes, then an 8-bit additive checksum of the payload. If the checksum
// matches, the block releases the core and serves its reads and writes.
// If it does not match, the core stays in reset and load_err is raised.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst         asynchronous active-high reset
//   ld_valid    loader byte valid
//   ld_data     loader byte
//   ld_ready    block accepts ld_data this cycle (registered)
//   core_addr   core address bus
//   core_rw     1 = core write, 0 = core read
//   core_wdata  core write data
//   core_rdata  combinational read data (8'h00 unless the core is running)
//   core_rst_n  active-low reset to the core, driven from a flop
//   load_done   image loaded and core running
//   load_err    checksum mismatch; stays set until rst
// ---------------------------------------------------------------------------
module bit8_boot_mem #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int REL_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_rw,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so a header of 0 can encode a full 2**ADDR_W byte image.
    localparam int LEN_W = ADDR_W + 1;
    localparam int REL_W = (REL_CYC < 2) ? 1 : $clog2(REL_CYC + 1);

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        CHK  = 3'd2,
        REL  = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] wptr;
    logic [DATA_W-1:0] sum;
    logic [REL_W-1:0]  rel_cnt;

    logic              xfer;
    logic              last_byte;
    logic              sum_ok;
    logic              rel_end;

    // Checksum accumulation wraps modulo 2**DATA_W.
    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    // Header byte to payload length; zero stands for the whole memory.
    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] d);
        if (d == '0)
            return LEN_W'(DEPTH);
        else
            return LEN_W'(d);
    endfunction

    assign xfer      = ld_valid & ld_ready;
    assign last_byte = ((cnt + LEN_W'(1)) == len);
    assign sum_ok    = (ld_data == sum);
    assign rel_end   = (rel_cnt == REL_W'(REL_CYC));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= HDR;
        else
            state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (xfer)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (xfer && last_byte)
                    state_nxt = CHK;
            end
            CHK: begin
                if (xfer)
                    state_nxt = sum_ok ? REL : ERR;
            end
            REL: begin
                if (rel_end)
                    state_nxt = RUN;
            end
            RUN:     state_nxt = RUN;
            ERR:     state_nxt = ERR;
            default: state_nxt = HDR;
        endcase
    end

    // -----------------------------------------------------------------------
    // Loader datapath and registered control outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= '0;
            cnt        <= '0;
            wptr       <= '0;
            sum        <= '0;
            rel_cnt    <= '0;
            ld_ready   <= 1'b0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // ld_ready is a flop, so it follows the state being entered; this
            // also keeps it low for the first cycle after rst falls.
            ld_ready <= (state_nxt == HDR) || (state_nxt == LOAD) ||
                        (state_nxt == CHK);
            case (state)
                HDR: begin
                    if (xfer) begin
                        len  <= hdr_len(ld_data);
                        cnt  <= '0;
                        wptr <= '0;
                        sum  <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        sum  <= add_mod(sum, ld_data);
                        // Wraps to zero only after a full-depth image; by
                        // then the FSM has left LOAD so no write follows.
                        wptr <= wptr + ADDR_W'(1);
                        cnt  <= cnt + LEN_W'(1);
                    end
                end
                CHK: begin
                    if (xfer) begin
                        rel_cnt <= '0;
                        if (!sum_ok)
                            load_err <= 1'b1;
                    end
                end
                REL: begin
                    // Core reset is held for REL_CYC+1 edges after the
                    // checksum byte, then released on the same edge that
                    // enters RUN.
                    rel_cnt <= rel_cnt + REL_W'(1);
                    if (rel_end) begin
                        core_rst_n <= 1'b1;
                        load_done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Memory array (not reset, contents survive rst)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == LOAD && xfer)
            mem[wptr] <= ld_data;
        else if (state == RUN && core_rw)
            mem[core_addr] <= core_wdata;
    end

    // Zero-latency read; a same-cycle write is only visible after the edge,
    // so a read of the address being written returns the old byte.
    assign core_rdata = (state == RUN) ? mem[core_addr] : '0;

endmodule
